axis_load_sweep_ctrl: RTL

Synthesizable sequencer for NoC traffic characterisation. Steps a programmable table of injection loads across NUM_ENDPOINTS traffic-generator/checker pairs. For each load point it resets the harness, starts all generators, waits for completion or timeout, drains, then emits one result record. It replaces testbench-side sweep loops so the same sweep runs on FPGA or in simulation.

---
 rtl/axis_load_sweep_ctrl.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axis_load_sweep_ctrl.sv
// Purpose : sequences a table of injection loads across NUM_ENDPOINTS TG/checker
//           pairs and emits one result record per load point.
// Latency : per point RESET_CYCLES + SETTLE_CYCLES + run + DRAIN_CYCLES + 1 report cycle;
//           tg_done and the counter sums are registered once before the exit decision.
// Backpressure: none; result_valid and sweep_done are single-cycle pulses that are not held.
//
// Ports: go/abort control the sweep, tbl_wr_* fill the load table while idle,
// harness_rst_n/load/start drive the harness, tg_done/chk_error/total_* are the
// harness status inputs, and result_* carry one record per completed load point.
module axis_load_sweep_ctrl #(
    parameter int NUM_ENDPOINTS  = 4,
    parameter int COUNT_WIDTH    = 32,
    parameter int LOAD_WIDTH     = 16,
    parameter int NUM_LOADS      = 12,
    parameter int RESET_CYCLES   = 7,
    parameter int SETTLE_CYCLES  = 5,
    parameter int MIN_RUN_CYCLES = 6,
    parameter int DRAIN_CYCLES   = 3,
    parameter int TIMEOUT_WIDTH  = 32
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        go,
    input  logic                                        abort,
    input  logic [$clog2(NUM_LOADS+1)-1:0]              num_loads,
    input  logic [TIMEOUT_WIDTH-1:0]                    timeout_cycles,
    input  logic                                        tbl_wr_en,
    input  logic [$clog2(NUM_LOADS)-1:0]                tbl_wr_addr,
    input  logic [LOAD_WIDTH-1:0]                       tbl_wr_data,
    output logic                                        harness_rst_n,
    output logic [LOAD_WIDTH-1:0]                       load,
    output logic [NUM_ENDPOINTS-1:0]                    start,
    input  logic [NUM_ENDPOINTS-1:0]                    tg_done,
    input  logic [NUM_ENDPOINTS-1:0]                    chk_error,
    input  logic [NUM_ENDPOINTS*COUNT_WIDTH-1:0]        total_sent,
    input  logic [NUM_ENDPOINTS*COUNT_WIDTH-1:0]        total_recv,
    output logic                                        busy,
    output logic                                        result_valid,
    output logic [$clog2(NUM_LOADS)-1:0]                result_idx,
    output logic [COUNT_WIDTH+$clog2(NUM_ENDPOINTS):0]  result_sent,
    output logic [COUNT_WIDTH+$clog2(NUM_ENDPOINTS):0]  result_recv,
    output logic [NUM_ENDPOINTS-1:0]                    result_err_mask,
    output logic                                        result_timeout,
    output logic [TIMEOUT_WIDTH-1:0]                    result_cycles,
    output logic                                        sweep_done
);

    localparam int IDX_W  = $clog2(NUM_LOADS);
    localparam int NL_W   = $clog2(NUM_LOADS + 1);
    localparam int SUM_W  = COUNT_WIDTH + $clog2(NUM_ENDPOINTS) + 1;
    localparam int TW     = TIMEOUT_WIDTH;
    localparam int PH_MAX = (RESET_CYCLES > SETTLE_CYCLES)
                          ? ((RESET_CYCLES > DRAIN_CYCLES) ? RESET_CYCLES : DRAIN_CYCLES)
                          : ((SETTLE_CYCLES > DRAIN_CYCLES) ? SETTLE_CYCLES : DRAIN_CYCLES);
    localparam int PH_W   = $clog2(PH_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HOLD_RST, S_SETTLE, S_RUN, S_DRAIN, S_REPORT, S_FINISH
    } state_t;

    state_t                   state_q, state_d;
    logic [PH_W-1:0]          ph_cnt_q, ph_cnt_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [NL_W-1:0]          n_loads_q, n_loads_d;
    logic [TW-1:0]            tmo_q, tmo_d;
    logic [LOAD_WIDTH-1:0]    load_q, load_d;
    logic [NUM_ENDPOINTS-1:0] start_q, start_d;
    logic [NUM_ENDPOINTS-1:0] done_q, done_d;
    logic [SUM_W-1:0]         sent_sum_q, sent_sum_d;
    logic [SUM_W-1:0]         recv_sum_q, recv_sum_d;
    logic [TW-1:0]            run_cnt_q, run_cnt_d;
    logic                     timed_out_q, timed_out_d;
    logic [IDX_W-1:0]         res_idx_q, res_idx_d;
    logic [SUM_W-1:0]         res_sent_q, res_sent_d;
    logic [SUM_W-1:0]         res_recv_q, res_recv_d;
    logic [NUM_ENDPOINTS-1:0] res_err_q, res_err_d;
    logic                     res_to_q, res_to_d;
    logic [TW-1:0]            res_cyc_q, res_cyc_d;
    logic [LOAD_WIDTH-1:0]    tbl_q [NUM_LOADS];
    logic [LOAD_WIDTH-1:0]    tbl_d [NUM_LOADS];

    logic                     tbl_wr_ok;
    logic                     last_pt;
    logic                     run_min;
    logic                     run_complete;
    logic                     run_expired;
    logic [NL_W-1:0]          n_loads_clamped;
    logic [SUM_W-1:0]         sent_in;
    logic [SUM_W-1:0]         recv_in;

    // The table is only writable while idle, so a sweep always sees a frozen table.
    assign tbl_wr_ok       = tbl_wr_en && (state_q == S_IDLE) && (32'(tbl_wr_addr) < NUM_LOADS);
    assign n_loads_clamped = ((num_loads == '0) || (32'(num_loads) > NUM_LOADS))
                           ? NL_W'(NUM_LOADS) : num_loads;
    assign last_pt         = (NL_W'(idx_q) == (n_loads_q - NL_W'(1)));
    assign run_min         = (run_cnt_q >= TW'(MIN_RUN_CYCLES));
    assign run_complete    = (&done_q) && (sent_sum_q == recv_sum_q);
    assign run_expired     = (tmo_q != '0) && (run_cnt_q >= tmo_q);

    // Full-width sums: the extra bits make overflow impossible.
    always_comb begin
        sent_in = '0;
        recv_in = '0;
        for (int i = 0; i < NUM_ENDPOINTS; i++) begin
            sent_in = sent_in + SUM_W'(total_sent[i*COUNT_WIDTH +: COUNT_WIDTH]);
            recv_in = recv_in + SUM_W'(total_recv[i*COUNT_WIDTH +: COUNT_WIDTH]);
        end
    end

    always_comb begin
        state_d     = state_q;
        ph_cnt_d    = ph_cnt_q;
        idx_d       = idx_q;
        n_loads_d   = n_loads_q;
        tmo_d       = tmo_q;
        load_d      = load_q;
        start_d     = start_q;
        done_d      = '0;
        sent_sum_d  = sent_sum_q;
        recv_sum_d  = recv_sum_q;
        run_cnt_d   = run_cnt_q;
        timed_out_d = timed_out_q;
        res_idx_d   = res_idx_q;
        res_sent_d  = res_sent_q;
        res_recv_d  = res_recv_q;
        res_err_d   = res_err_q;
        res_to_d    = res_to_q;
        res_cyc_d   = res_cyc_q;
        tbl_d       = tbl_q;

        if (tbl_wr_ok) begin
            tbl_d[tbl_wr_addr] = tbl_wr_data;
        end

        if (abort) begin
            state_d = S_IDLE;
            start_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        n_loads_d = n_loads_clamped;
                        tmo_d     = timeout_cycles;
                        idx_d     = '0;
                        ph_cnt_d  = '0;
                        // Bypass a table write to entry 0 landing on the go cycle.
                        load_d    = (tbl_wr_ok && (tbl_wr_addr == '0)) ? tbl_wr_data : tbl_q[0];
                        state_d   = S_HOLD_RST;
                    end
                end
                S_HOLD_RST: begin
                    if (ph_cnt_q == PH_W'(RESET_CYCLES - 1)) begin
                        ph_cnt_d = '0;
                        state_d  = S_SETTLE;
                    end else begin
                        ph_cnt_d = ph_cnt_q + PH_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (ph_cnt_q == PH_W'(SETTLE_CYCLES - 1)) begin
                        ph_cnt_d  = '0;
                        start_d   = '1;
                        run_cnt_d = '0;
                        state_d   = S_RUN;
                    end else begin
                        ph_cnt_d = ph_cnt_q + PH_W'(1);
                    end
                end
                S_RUN: begin
                    done_d     = tg_done;
                    sent_sum_d = sent_in;
                    recv_sum_d = recv_in;
                    // Once an endpoint reports done its start stays low for the point.
                    start_d    = start_q & ~done_q;
                    run_cnt_d  = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + TW'(1);
                    if (run_min && (run_complete || run_expired)) begin
                        // Freeze the values the decision was made on; they become the record.
                        timed_out_d = !run_complete;
                        sent_sum_d  = sent_sum_q;
                        recv_sum_d  = recv_sum_q;
                        run_cnt_d   = run_cnt_q;
                        start_d     = '0;
                        ph_cnt_d    = '0;
                        state_d     = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (ph_cnt_q == PH_W'(DRAIN_CYCLES - 1)) begin
                        ph_cnt_d   = '0;
                        res_idx_d  = idx_q;
                        res_sent_d = sent_sum_q;
                        res_recv_d = recv_sum_q;
                        res_err_d  = chk_error;
                        res_to_d   = timed_out_q;
                        res_cyc_d  = run_cnt_q;
                        state_d    = S_REPORT;
                    end else begin
                        ph_cnt_d = ph_cnt_q + PH_W'(1);
                    end
                end
                S_REPORT: begin
                    if (last_pt) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d    = idx_q + IDX_W'(1);
                        load_d   = tbl_q[idx_q + IDX_W'(1)];
                        ph_cnt_d = '0;
                        state_d  = S_HOLD_RST;
                    end
                end
                S_FINISH: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    start_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ph_cnt_q    <= '0;
            idx_q       <= '0;
            n_loads_q   <= '0;
            tmo_q       <= '0;
            load_q      <= '0;
            start_q     <= '0;
            done_q      <= '0;
            sent_sum_q  <= '0;
            recv_sum_q  <= '0;
            run_cnt_q   <= '0;
            timed_out_q <= 1'b0;
            res_idx_q   <= '0;
            res_sent_q  <= '0;
            res_recv_q  <= '0;
            res_err_q   <= '0;
            res_to_q    <= 1'b0;
            res_cyc_q   <= '0;
            tbl_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            ph_cnt_q    <= ph_cnt_d;
            idx_q       <= idx_d;
            n_loads_q   <= n_loads_d;
            tmo_q       <= tmo_d;
            load_q      <= load_d;
            start_q     <= start_d;
            done_q      <= done_d;
            sent_sum_q  <= sent_sum_d;
            recv_sum_q  <= recv_sum_d;
            run_cnt_q   <= run_cnt_d;
            timed_out_q <= timed_out_d;
            res_idx_q   <= res_idx_d;
            res_sent_q  <= res_sent_d;
            res_recv_q  <= res_recv_d;
            res_err_q   <= res_err_d;
            res_to_q    <= res_to_d;
            res_cyc_q   <= res_cyc_d;
            tbl_q       <= tbl_d;
        end
    end

    // The harness is held in reset while idle and during the per-point reset window.
    assign harness_rst_n   = (state_q != S_IDLE) && (state_q != S_HOLD_RST);
    assign busy            = (state_q != S_IDLE);
    assign result_valid    = (state_q == S_REPORT);
    assign sweep_done      = (state_q == S_FINISH);
    assign load            = load_q;
    assign start           = start_q;
    assign result_idx      = res_idx_q;
    assign result_sent     = res_sent_q;
    assign result_recv     = res_recv_q;
    assign result_err_mask = res_err_q;
    assign result_timeout  = res_to_q;
    assign result_cycles   = res_cyc_q;

endmodule
